// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared opcodes, FSM states and instruction field positions for the ALU issue stage
package alu_issue_pkg;
    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int AW     = 2;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0001;
    localparam logic [3:0] OP_CLR = 4'b1010;
    localparam logic [3:0] OP_LDI = 4'b1000;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 9;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 1;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_CLR};
    endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4x8 register file, two operand read ports plus a debug read port, one write port
module alu_regfile
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_i,
    input  logic [AW-1:0]     rb_i,
    input  logic [AW-1:0]     dbg_i,
    output logic [DATA_W-1:0] ra_o,
    output logic [DATA_W-1:0] rb_o,
    output logic [DATA_W-1:0] dbg_o,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i
);
    logic [DATA_W-1:0] rf_q [NREG];

    assign ra_o  = rf_q[ra_i];
    assign rb_o  = rf_q[rb_i];
    assign dbg_o = rf_q[dbg_i];

    // clear every entry on reset, otherwise write one entry per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (we_i) begin
            rf_q[wa_i] <= wd_i;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage feeding the 8-bit ALU and writing its result back; ISSUE_OVERLAP_EN enables overlapped issue with forwarding
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_mode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done_valid,
    output logic [AW-1:0]     done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              done_zero,
    output logic              err_sticky,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
`ifdef ISSUE_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif
    state_t state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, imm_q, imm_d;
    logic [DATA_W-1:0] done_data_q, done_data_d, rf_a, rf_b, wb_data;
    logic [3:0] alu_mode_q, alu_mode_d, op;
    logic [AW-1:0] rd_q, rd_d, done_rd_q, done_rd_d, rd, ra, rb;
    logic ldi_q, ldi_d, err_q, err_d, done_valid_q, done_valid_d, done_zero_q, done_zero_d;
    logic accept, in_exec, is_alu, is_ldi, is_ill, fwd_a, fwd_b;

    assign op       = in_instr[OP_MSB:OP_LSB];
    assign rd       = in_instr[RD_MSB:RD_LSB];
    assign ra       = in_instr[RA_MSB:RA_LSB];
    assign rb       = in_instr[RB_MSB:RB_LSB];
    assign is_alu   = is_alu_op(op);
    assign is_ldi   = (op == OP_LDI);
    assign is_ill   = !is_alu && !is_ldi;
    assign in_exec  = (state_q == EXEC);
    assign in_ready = OVERLAP || !in_exec;
    assign accept   = in_valid && in_ready;
    assign wb_data  = ldi_q ? imm_q : alu_result;
    assign fwd_a    = OVERLAP && in_exec && (ra == rd_q);
    assign fwd_b    = OVERLAP && in_exec && (rb == rd_q);

    alu_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra_i  (ra),
        .rb_i  (rb),
        .dbg_i (dbg_addr),
        .ra_o  (rf_a),
        .rb_o  (rf_b),
        .dbg_o (dbg_data),
        .we_i  (in_exec),
        .wa_i  (rd_q),
        .wd_i  (wb_data)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // any legal accept enters (or stays in) EXEC; EXEC otherwise falls back to IDLE
    always_comb begin
        state_d = (accept && !is_ill) ? EXEC : IDLE;
    end

    // issue operands on accept and stage the retirement report of the in-flight instruction
    always_comb begin
        alu_a_d      = (accept && is_alu) ? (fwd_a ? wb_data : rf_a) : alu_a_q;
        alu_b_d      = (accept && is_alu) ? (fwd_b ? wb_data : rf_b) : alu_b_q;
        alu_mode_d   = !accept ? alu_mode_q : (is_alu ? op : OP_CLR);
        rd_d         = (accept && !is_ill) ? rd : rd_q;
        ldi_d        = (accept && !is_ill) ? is_ldi : ldi_q;
        imm_d        = (accept && !is_ill) ? in_instr[IMM_MSB:IMM_LSB] : imm_q;
        err_d        = err_q || (accept && is_ill);
        done_valid_d = in_exec;
        done_rd_d    = in_exec ? rd_q : done_rd_q;
        done_data_d  = in_exec ? wb_data : done_data_q;
        done_zero_d  = in_exec ? (wb_data == '0) : done_zero_q;
    end

    // datapath registers; reset drops any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_mode_q   <= OP_CLR;
            rd_q         <= '0;
            ldi_q        <= 1'b0;
            imm_q        <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_rd_q    <= '0;
            done_data_q  <= '0;
            done_zero_q  <= 1'b0;
        end else begin
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_mode_q   <= alu_mode_d;
            rd_q         <= rd_d;
            ldi_q        <= ldi_d;
            imm_q        <= imm_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
            done_rd_q    <= done_rd_d;
            done_data_q  <= done_data_d;
            done_zero_q  <= done_zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_mode   = alu_mode_q;
    assign err_sticky = err_q;
    assign done_valid = done_valid_q;
    assign done_rd    = done_rd_q;
    assign done_data  = done_data_q;
    assign done_zero  = done_zero_q;
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream issue stage for the 8-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4-entry register file. It drives the ALU's a, b and aluMode inputs from registers, then writes the ALU's combinational result back into the register file. It also reports each completed instruction on a one-cycle done strobe.

Parameters:
DATA_W, 8, datapath width; must match the ALU (only 8 is supported)
NREG, 4, register file depth; fixed by the 2-bit register fields

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept an instruction this cycle
in_instr  in  16  [15:12] op, [11:10] rd, [9:8] ra, [1:0] rb, [7:0] imm (LDI only)
alu_a  out  8  operand A to ALU
alu_b  out  8  operand B to ALU
alu_mode  out  4  aluMode to ALU
alu_result  in  8  ALU output s (combinational)
done_valid  out  1  one-cycle pulse: instruction retired
done_rd  out  2  destination of the retired instruction
done_data  out  8  value written to rd
done_zero  out  1  done_data == 0
err_sticky  out  1  illegal opcode seen since reset
dbg_addr  in  2  debug read address
dbg_data  out  8  rf[dbg_addr], combinational

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: every register-file entry 0x00; alu_a = alu_b = 0x00; alu_mode = 4'b1010 (CLEAR); done_* all 0; err_sticky 0; state IDLE.
- Reset mid-operation: any in-flight instruction is dropped with no writeback and no done pulse.
- Opcodes: ADD 0011, SUB 0100, AND 0101, OR 0110, NOT 0001, CLR 1010 (all forwarded to the ALU); LDI 1000 (local). Any other op is illegal.
- Handshake: a transfer occurs when in_valid && in_ready at a rising edge. in_ready = (state == IDLE); with ISSUE_OVERLAP_EN see below.
- Register file reads are combinational.
- States: IDLE, EXEC.
- IDLE, on accept of an ALU opcode:
  - alu_a <= rf[ra], alu_b <= rf[rb], alu_mode <= op.
  - Latch rd; go to EXEC.
- IDLE, on accept of LDI:
  - Latch imm as the pending result; alu_mode <= CLR.
  - Go to EXEC; uniform latency for all opcodes.
- IDLE, on accept of an illegal op:
  - err_sticky <= 1; alu_mode <= CLR.
  - No state change, no writeback, no done pulse.
- EXEC, at the next edge, always returns to IDLE:
  - Write rf[rd] <= (LDI ? imm : alu_result).
  - done_valid <= 1 with done_rd / done_data / done_zero.
- Latency: done_valid is high during the second cycle after accept. Base throughput is one instruction per 2 cycles.
- done_valid deasserts after one cycle unless another instruction retires.
- alu_a, alu_b and alu_mode hold their values outside EXEC; the ALU must never see an undefined mode.
- Width: all arithmetic happens in the ALU, modulo 2^8. This block never widens or carries.
- rd == ra or rd == rb: the operand is read before the writeback, giving old-value semantics.
- dbg_data shows the pre-write value during the writeback cycle and the new value after the edge.

Optional Feature:
ISSUE_OVERLAP_EN
- Defined:
  - in_ready = 1 in both IDLE and EXEC, giving 1 instruction/cycle.
  - An instruction accepted during EXEC issues at the same edge as the prior writeback; the state stays EXEC.
  - If the new ra or rb equals the in-flight rd, that operand takes the forwarded value (LDI ? imm : alu_result) instead of rf.
  - Illegal ops accepted during EXEC: set err_sticky; the in-flight instruction still retires; the next state is IDLE.
- Undefined: in_ready only in IDLE, with no forwarding logic.

Decomposition:
- Package alu_issue_pkg: opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_CLR, OP_LDI), state enum (IDLE, EXEC), instruction field bit positions.
- Sub-module alu_regfile: 4x8, two combinational read ports plus the debug port, one synchronous write port, synchronous active-low reset to zero.

Test Plan:
- Reset, then LDI r1=0x05, LDI r2=0x03 -> done_data 0x05 then 0x03; dbg r1=0x05, r2=0x03.
- ADD r3,r1,r2 -> alu_mode=0011, alu_a=05, alu_b=03; done_rd=3, done_data=0x08, done_zero=0.
- SUB r0,r2,r1 -> 0xFE (wrap); AND r1&r2 -> 0x01; OR -> 0x07; NOT r1 -> 0xFA.
- CLR r3 -> done_data 0x00, done_zero=1; then op 1111 -> err_sticky=1, no done pulse, rf unchanged, alu_mode=1010.
- ADD accepted, rst_n low in the EXEC cycle -> no done pulse, all rf = 0x00, in_ready=1 after reset.
- ISSUE_OVERLAP_EN: LDI r1=0x10 then ADD r2,r1,r1 back-to-back -> in_ready stays high, forwarded r1, done_data 0x20 one cycle after 0x10.
